ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//  - Accepts one MUL*/DIV*/REM* request from ID and stalls the front of the pipeline while it iterates.
//  - Presents a registered result plus destination register for one cycle, which EX muxes into its ALU-result register.
//  - Supports abort on EX flush.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  6   iteration counter width; must hold XLEN (=$clog2(XLEN)+1)
// PORTS
//  Clk            in   1     clock, rising edge
//  Reset_n        in   1     asynchronous, active-low reset
//  MD_Start       in   1     ID holds a valid M-extension op (level; sampled only in IDLE)
//  MD_Op          in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  MD_Rs1_data    in   XLEN  operand A (already forwarded)
//  MD_Rs2_data    in   XLEN  operand B (already forwarded)
//  MD_Rd_addr     in   5     destination register
//  EX_Flush       in   1     abort any op in flight
//  MD_Stall       out  1     hold PC/IF/ID; combinational
//  MD_Busy        out  1     state is CALC or FIXUP (registered)
//  MD_Done        out  1     one-cycle valid pulse for MD_Result
//  MD_Result      out  XLEN  final result, valid while MD_Done
//  MD_Rd_addr_out out  5     Rd captured at accept
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//  - state=IDLE; all outputs 0; internal acc/operand/counter registers 0.
//  States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
//  IDLE:
//  - Accept when MD_Start=1 and EX_Flush=0.
//  - Latch |A| and |B| (signed ops only), sign flags, op, and Rd; cnt=XLEN.
//  - Next state is CALC.
//  - Special cases bypass CALC and go straight to DONE:
//    - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> A.
//    - DIV overflow, A=0x8000_0000 and B=-1: DIV -> 0x8000_0000; REM -> 0.
//  CALC (one bit per cycle; cnt decrements; leave at cnt==1):
//  - Multiply: shift-add into 2*XLEN product.
//  - Divide: restoring, one quotient bit per cycle.
//  FIXUP (one cycle):
//  - Negate the result per the latched signs.
//    - MULH/MULHSU: sign = sA^sB (MULHSU uses sB=0).
//    - Quotient: sA^sB. Remainder: sA.
//  - Select the output: MUL -> low XLEN; MULH* -> high XLEN; DIV* -> quotient; REM* -> remainder.
//  DONE (one cycle): MD_Done=1 with MD_Result and MD_Rd_addr_out; then IDLE.
//  Latency (accept edge = cycle N):
//  - Normal op: MD_Done high in cycle N+XLEN+2 (34 for XLEN=32).
//  - Special case: MD_Done high in cycle N+1.
//  MD_Stall = (IDLE & MD_Start & ~EX_Flush) | CALC | FIXUP.
//  - Low in DONE, so the pipeline advances in the same cycle the result is consumed.
//  - MD_Start seen in DONE is not re-accepted. ID deasserts it once the instruction moves on.
//  EX_Flush=1 in any state:
//  - Next state is IDLE; MD_Done is forced 0 that cycle; no result is produced.
//  - Flush has priority over an accept in the same cycle.
//  MD_Done, MD_Result and MD_Rd_addr_out are registered. MD_Result holds its value after DONE until the next DONE.
//  All arithmetic is unsigned on magnitudes. Negation is two's complement, XLEN wide (wrap, no saturation).
// STRUCTURE
//  Shared package ex_pkg:
//  - typedef enum logic [2:0] md_op_t (MD_MUL..MD_REMU).
//  - typedef enum logic [1:0] md_state_t (MD_IDLE, MD_CALC, MD_FIXUP, MD_DONE).
//  - localparam MD_XLEN = 32.
//  Sub-module ex_muldiv_dp:
//  - Contains the shift/add/subtract registers and the per-cycle step.
//  - Controlled by the FSM through step, load and fixup strobes.
//  The top level holds the FSM, counter, special-case detect and output registers.
// TESTING
//  1. MUL 7*-3 (0x7, 0xFFFF_FFFD) -> MD_Done at N+34, MD_Result=0xFFFF_FFEB; MD_Stall high for exactly 33 cycles.
//  2. MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000. MULHU same operands -> 0x4000_0000. MULHSU(-1,0xFFFF_FFFF) -> 0xFFFF_FFFF.
//  3. DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. DIV x/0 -> 0xFFFF_FFFF and REMU 5/0 -> 5, both at N+1. DIV 0x8000_0000/-1 -> 0x8000_0000 and REM -> 0, both at N+1.
//  5. EX_Flush at CALC cycle 10 -> IDLE next cycle, MD_Done never pulses. A new op accepted next completes correctly.
//  6. Reset_n low mid-CALC (async, between edges) -> outputs 0 immediately. After release, MD_Start with DIVU 9/3 -> 3.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared EX-stage types for the iterative multiply/divide sequencer.
// Op encodings follow RV32M funct3.
package ex_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_dp.sv
// Shift/add/subtract datapath for the multiply/divide sequencer.
// hi:lo holds the product, or remainder:quotient while dividing.
module ex_muldiv_dp
    import ex_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            special_i,
    input  logic [XLEN-1:0] spec_val_i,
    input  md_op_t          op_i,
    input  logic            neg_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            step_i,
    input  logic            fixup_i,
    output logic [XLEN-1:0] res_o
);

    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q;
    logic [XLEN-1:0]   res_q, fix_val;
    md_op_t            op_q;
    logic              neg_q;
    logic              is_div;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] prod, prod_n;
    logic [XLEN-1:0]   dsel;

    assign is_div = op_q[2];

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        if (is_div) begin
            // Restoring step: keep the trial remainder only when no borrow.
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod    = {hi_q, lo_q};
        prod_n  = neg_q ? (~prod + 1'b1) : prod;
        dsel    = op_q[1] ? hi_q : lo_q;
        fix_val = '0;
        if (is_div)
            fix_val = neg_q ? (~dsel + 1'b1) : dsel;
        else if (op_q == MD_MUL)
            fix_val = prod_n[XLEN-1:0];
        else
            fix_val = prod_n[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= MD_MUL;
            neg_q <= 1'b0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            op_q  <= op_i;
            neg_q <= neg_i;
            if (special_i)
                res_q <= spec_val_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end else if (fixup_i) begin
            res_q <= fix_val;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Holds the FSM, iteration counter, special-case detect and output flags.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            MD_Start,
    input  logic [2:0]      MD_Op,
    input  logic [XLEN-1:0] MD_Rs1_data,
    input  logic [XLEN-1:0] MD_Rs2_data,
    input  logic [4:0]      MD_Rd_addr,
    input  logic            EX_Flush,
    output logic            MD_Stall,
    output logic            MD_Busy,
    output logic            MD_Done,
    output logic [XLEN-1:0] MD_Result,
    output logic [4:0]      MD_Rd_addr_out
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [4:0]       rd_q;
    logic             accept, step, fixup;
    logic             is_div, is_rem, is_uns;
    logic             b_zero, ovf, special;
    logic             sa_en, sb_en, s_a, s_b, neg;
    logic [XLEN-1:0]  spec_val, abs_a, abs_b;
    md_op_t           op;

    assign op     = md_op_t'(MD_Op);
    assign is_div = MD_Op[2];
    assign is_rem = MD_Op[1];
    assign is_uns = MD_Op[0];
    assign b_zero = (MD_Rs2_data == '0);
    assign ovf    = is_div & ~is_uns & (MD_Rs2_data == '1)
                  & (MD_Rs1_data == {1'b1, {(XLEN-1){1'b0}}});
    assign special = is_div & (b_zero | ovf);

    always_comb begin
        if (b_zero)
            spec_val = is_rem ? MD_Rs1_data : '1;
        else
            spec_val = is_rem ? '0 : MD_Rs1_data;
    end

    assign sa_en = (op == MD_MULH) | (op == MD_MULHSU)
                 | (op == MD_DIV)  | (op == MD_REM);
    assign sb_en = (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM);
    assign s_a   = sa_en & MD_Rs1_data[XLEN-1];
    assign s_b   = sb_en & MD_Rs2_data[XLEN-1];
    assign abs_a = s_a ? (~MD_Rs1_data + 1'b1) : MD_Rs1_data;
    assign abs_b = s_b ? (~MD_Rs2_data + 1'b1) : MD_Rs2_data;
    // Remainder takes the dividend's sign; everything else the product sign.
    assign neg   = (is_div & is_rem) ? s_a : (s_a ^ s_b);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        fixup   = 1'b0;
        if (EX_Flush) begin
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (MD_Start) begin
                        accept  = 1'b1;
                        state_d = special ? MD_DONE : MD_CALC;
                    end
                end
                MD_CALC: begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_d = MD_FIXUP;
                end
                MD_FIXUP: begin
                    fixup   = 1'b1;
                    state_d = MD_DONE;
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == MD_CALC) | (state_d == MD_FIXUP);
            done_q  <= (state_d == MD_DONE);
            if (accept) begin
                cnt_q <= CNT_W'(XLEN);
                rd_q  <= MD_Rd_addr;
            end else if (step) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    ex_muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .load_i    (accept),
        .special_i (special),
        .spec_val_i(spec_val),
        .op_i      (op),
        .neg_i     (neg),
        .a_i       (abs_a),
        .b_i       (abs_b),
        .step_i    (step),
        .fixup_i   (fixup),
        .res_o     (MD_Result)
    );

    assign MD_Stall = Reset_n & (((state_q == MD_IDLE) & MD_Start & ~EX_Flush)
                    | (state_q == MD_CALC) | (state_q == MD_FIXUP));
    assign MD_Busy        = busy_q;
    assign MD_Done        = done_q & ~EX_Flush;
    assign MD_Rd_addr_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
// Cycle k after the accept edge is sampled on the k-th falling edge.
module tb_ex_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        MD_Start;
    logic [2:0]  MD_Op;
    logic [31:0] MD_Rs1_data;
    logic [31:0] MD_Rs2_data;
    logic [4:0]  MD_Rd_addr;
    logic        EX_Flush;
    logic        MD_Stall;
    logic        MD_Busy;
    logic        MD_Done;
    logic [31:0] MD_Result;
    logic [4:0]  MD_Rd_addr_out;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ex_muldiv_unit dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .MD_Start      (MD_Start),
        .MD_Op         (MD_Op),
        .MD_Rs1_data   (MD_Rs1_data),
        .MD_Rs2_data   (MD_Rs2_data),
        .MD_Rd_addr    (MD_Rd_addr),
        .EX_Flush      (EX_Flush),
        .MD_Stall      (MD_Stall),
        .MD_Busy       (MD_Busy),
        .MD_Done       (MD_Done),
        .MD_Result     (MD_Result),
        .MD_Rd_addr_out(MD_Rd_addr_out)
    );

    // Issue one op and wait for MD_Done; reports latency, stall count, result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output int lat, output int stalls,
                          output logic [31:0] res, output logic [4:0] rd_o);
        lat    = -1;
        stalls = 0;
        res    = '0;
        rd_o   = '0;
        @(posedge Clk);
        #1;
        MD_Start    = 1'b1;
        MD_Op       = op;
        MD_Rs1_data = a;
        MD_Rs2_data = b;
        MD_Rd_addr  = rd;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (MD_Done) begin
                lat  = k;
                res  = MD_Result;
                rd_o = MD_Rd_addr_out;
                break;
            end
            if (MD_Stall) stalls++;
        end
    endtask

    task automatic test_reset;
        Reset_n     = 1'b0;
        MD_Start    = 1'b0;
        MD_Op       = 3'd0;
        MD_Rs1_data = '0;
        MD_Rs2_data = '0;
        MD_Rd_addr  = '0;
        EX_Flush    = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({MD_Stall, MD_Busy, MD_Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {MD_Stall, MD_Busy, MD_Done});
        end
        checks++;
        if (MD_Result !== 32'h0 || MD_Rd_addr_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 0/0", MD_Result, MD_Rd_addr_out);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (MD_Busy !== 1'b0 || MD_Stall !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy %b stall %b want 0 0", MD_Busy, MD_Stall);
        end
    endtask

    task automatic test_mul;
        int lat, st;
        logic [31:0] r;
        logic [4:0] rd;
        run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd11, lat, st, r, rd);
        checks++;
        if (r !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_result got %h want FFFFFFEB", r);
        end
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL mul_latency got %0d want 34", lat);
        end
        checks++;
        if (st !== 33) begin
            errors++;
            $display("FAIL mul_stall_cycles got %0d want 33", st);
        end
        checks++;
        if (rd !== 5'd11) begin
            errors++;
            $display("FAIL mul_rd got %0d want 11", rd);
        end
        @(negedge Clk);
        checks++;
        if (MD_Done !== 1'b0 || MD_Result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_after_done done %b res %h want 0 FFFFFFEB", MD_Done, MD_Result);
        end
    endtask

    task automatic test_mulh;
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        int lat, st;
        logic [31:0] r;
        logic [4:0] rd;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 1), lat, st, r, rd);
            checks++;
            if (r !== exp[i] || lat !== 34) begin
                errors++;
                $display("FAIL mulh_%0d got %h lat %0d want %h lat 34", i, r, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat, st;
        logic [31:0] r;
        logic [4:0] rd;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 20), lat, st, r, rd);
            checks++;
            if (r !== exp[i] || lat !== 34 || rd !== 5'(i + 20)) begin
                errors++;
                $display("FAIL div_%0d got %h lat %0d rd %0d want %h lat 34 rd %0d",
                         i, r, lat, rd, exp[i], i + 20);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  ops [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd1234, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int lat, st;
        logic [31:0] r;
        logic [4:0] rd;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd9, lat, st, r, rd);
            checks++;
            if (r !== exp[i]) begin
                errors++;
                $display("FAIL special_res_%0d got %h want %h", i, r, exp[i]);
            end
            checks++;
            if (lat !== 1 || st !== 0) begin
                errors++;
                $display("FAIL special_lat_%0d got lat %0d stall %0d want 1 0", i, lat, st);
            end
        end
    endtask

    task automatic test_flush;
        int lat, st, dones;
        logic [31:0] r;
        logic [4:0] rd;
        @(posedge Clk);
        #1;
        MD_Start    = 1'b1;
        MD_Op       = 3'd5;
        MD_Rs1_data = 32'd1000;
        MD_Rs2_data = 32'd3;
        MD_Rd_addr  = 5'd4;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        repeat (10) @(negedge Clk);
        checks++;
        if (MD_Busy !== 1'b1 || MD_Stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_calc_busy busy %b stall %b want 1 1", MD_Busy, MD_Stall);
        end
        EX_Flush = 1'b1;
        @(posedge Clk);
        #1;
        EX_Flush = 1'b0;
        @(negedge Clk);
        checks++;
        if (MD_Busy !== 1'b0 || MD_Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle busy %b stall %b want 0 0", MD_Busy, MD_Stall);
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (MD_Done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL flush_no_done got %0d pulses want 0", dones);
        end
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd6, lat, st, r, rd);
        checks++;
        if (r !== 32'h1 || lat !== 34 || rd !== 5'd6) begin
            errors++;
            $display("FAIL flush_next_op got %h lat %0d rd %0d want 1 34 6", r, lat, rd);
        end
    endtask

    task automatic test_async_reset;
        int lat, st;
        logic [31:0] r;
        logic [4:0] rd;
        @(posedge Clk);
        #1;
        MD_Start    = 1'b1;
        MD_Op       = 3'd0;
        MD_Rs1_data = 32'd3;
        MD_Rs2_data = 32'd5;
        MD_Rd_addr  = 5'd17;
        @(posedge Clk);
        #1;
        repeat (5) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({MD_Stall, MD_Busy, MD_Done} !== 3'b000) begin
            errors++;
            $display("FAIL async_rst_flags got %b want 000", {MD_Stall, MD_Busy, MD_Done});
        end
        checks++;
        if (MD_Result !== 32'h0 || MD_Rd_addr_out !== 5'd0) begin
            errors++;
            $display("FAIL async_rst_data got %h/%0d want 0/0", MD_Result, MD_Rd_addr_out);
        end
        MD_Start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        run_op(3'd5, 32'd9, 32'd3, 5'd2, lat, st, r, rd);
        checks++;
        if (r !== 32'd3 || lat !== 34 || rd !== 5'd2) begin
            errors++;
            $display("FAIL async_rst_divu got %h lat %0d rd %0d want 3 34 2", r, lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
